traffic_lamp_monitor: RTL and testbench
=======================================

TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 Parameter MIN_YELLOW, default 3, minimum legal yellow dwell in cycles (1..31).
REQ-002 Parameter MAX_PHASE, default 12, maximum legal GREEN or YELLOW dwell in cycles (1..31).
REQ-003 Parameter FLASH_HALF, default 4, half-period of the fault flash in cycles (1..15).
REQ-004 Parameter STARTUP_CYC, default 4, all-red hold after reset or fault clear, in cycles (1..15).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 main_light  input  2  main-road light code from the controller: RED=00, GREEN=01, YELLOW=10; 11 is invalid.
REQ-008 side_light  input  2  side-road light code, same encoding as main_light.
REQ-009 fault_clr  input  1  operator request to leave FAULT; level-sampled.
REQ-010 main_lamp  output  3  registered one-hot lamp drive {red,yellow,green}.
REQ-011 side_lamp  output  3  registered one-hot lamp drive {red,yellow,green}.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 fault_code  output  3  latched cause: 0 none, 1 conflict, 2 invalid code, 3 illegal transition, 4 short yellow, 5 stuck phase.
REQ-014 mode  output  2  current state: STARTUP=00, NORMAL=01, FAULT=10.

Function
REQ-015 The FSM SHALL have states STARTUP, NORMAL and FAULT; 11 is unreachable and SHALL recover to FAULT with code 2.
REQ-016 STARTUP: both lamps SHALL be 100 and checks disabled; after STARTUP_CYC cycles the FSM SHALL go to NORMAL.
REQ-017 NORMAL: each lamp SHALL decode its code with 1-cycle latency (00->100, 01->001, 10->010).
REQ-018 Per-direction history SHALL hold the previous code and a 5-bit dwell counter: 1 on the first cycle of a new code, +1 while the code is unchanged, saturating at 31.
REQ-019 The history SHALL update in every state, so NORMAL checks start from valid history.
REQ-020 Conflict (1): both codes non-RED in the same cycle.
REQ-021 Invalid (2): either code equal to 11.
REQ-022 Illegal transition (3): a code change other than RED->GREEN, GREEN->YELLOW or YELLOW->RED.
REQ-023 Short yellow (4): YELLOW->RED with YELLOW dwell < MIN_YELLOW.
REQ-024 Stuck (5): a GREEN or YELLOW dwell reaching MAX_PHASE+1; all-red dwell is unlimited.
REQ-025 Simultaneous faults in one cycle SHALL latch the lowest code number.
REQ-026 A fault detected in NORMAL in cycle N SHALL set fault=1, mode=FAULT and fault_code in cycle N+1, and SHALL keep the code sticky until it is cleared.
REQ-027 FAULT: both lamps SHALL be {flash,0,0}; flash SHALL be 1 on the first FAULT cycle and toggle every FLASH_HALF cycles.
REQ-028 Input codes SHALL be ignored for lamp drive while in FAULT.
REQ-029 FAULT SHALL exit to STARTUP only when fault_clr=1 and both codes are RED in the same cycle.
REQ-030 On FAULT exit, fault_code and fault SHALL clear in the next cycle.
REQ-031 fault_clr outside FAULT SHALL have no effect.

Reset
REQ-032 Reset SHALL force: mode=STARTUP; main_lamp=side_lamp=100; fault=0; fault_code=0; dwell counters 0; previous codes RED; flash counter 0.
REQ-033 Reset asserted mid-FAULT or mid-flash SHALL take effect immediately, and the block SHALL restart the STARTUP hold on release.

Structure
REQ-034 A shared package SHALL hold the light codes (RED/GREEN/YELLOW), the mode encodings and the fault-code constants, for reuse by the controller and the bench.
REQ-035 One sub-module, lamp_dwell_tracker, SHALL be instantiated per direction, holding the previous-code register and dwell counter and flagging illegal-transition, short-yellow and stuck conditions.

Verification
REQ-036 Reset, then main cycles GREEN 6 / YELLOW 3 / RED while side mirrors it -> after 4 startup cycles mode=01, lamps track the codes with 1-cycle lag, and fault stays 0 for 200 cycles.
REQ-037 In NORMAL, drive main=01, side=01 for 1 cycle -> next cycle fault=1, fault_code=1, lamps 100/100, then 000/000 after 4 cycles.
REQ-038 Drive main YELLOW for 2 cycles then RED (MIN_YELLOW=3) -> fault_code=4; in the same cycle also drive side=11 -> fault_code=2 (priority).
REQ-039 Hold main GREEN for 13 cycles -> fault_code=5 on the cycle after dwell 13; main GREEN->RED directly -> fault_code=3.
REQ-040 In FAULT, pulse fault_clr with main=01 -> remains FAULT; fault_clr with both 00 -> mode=STARTUP, fault=0, and NORMAL 4 cycles later.
REQ-041 Assert reset during FAULT flash -> outputs immediately 100/100, fault=0, mode=00.

Source files
------------

// File: rtl/traffic_lamp_monitor_pkg.sv
// traffic_lamp_monitor_pkg
// Shared definitions for the traffic lamp monitor and its users. It holds the
// controller light codes, the monitor mode encoding, the latched fault-cause
// codes, the one-hot lamp patterns, and small helper functions (lamp decode,
// legal-sequence test, fault priority encode).
package traffic_lamp_monitor_pkg;

  // Controller light codes
  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_INVALID = 2'b11;

  // Monitor mode; 2'b11 is deliberately left unencoded (recovered to FAULT)
  typedef enum logic [1:0] {
    MODE_STARTUP = 2'b00,
    MODE_NORMAL  = 2'b01,
    MODE_FAULT   = 2'b10
  } mode_e;

  // Latched fault causes; a lower number has higher priority
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_CONFLICT     = 3'd1;
  localparam logic [2:0] FC_INVALID      = 3'd2;
  localparam logic [2:0] FC_ILLEGAL      = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
  localparam logic [2:0] FC_STUCK        = 3'd5;

  // One-hot lamp drive {red,yellow,green}
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_OFF    = 3'b000;

  // Per-cycle fault conditions, ordered by priority
  typedef struct packed {
    logic conflict;
    logic invalid;
    logic illegal;
    logic short_yellow;
    logic stuck;
  } fault_flags_t;

  // Light code to lamp pattern; the invalid code falls back to red so a
  // lamp is never driven dark or green by garbage input.
  function automatic logic [2:0] decode_lamp(input logic [1:0] code);
    logic [2:0] lamp;
    case (code)
      LIGHT_RED:    lamp = LAMP_RED;
      LIGHT_GREEN:  lamp = LAMP_GREEN;
      LIGHT_YELLOW: lamp = LAMP_YELLOW;
      default:      lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  // True for the only permitted code changes: RED->GREEN->YELLOW->RED
  function automatic logic legal_step(input logic [1:0] prev_code,
                                      input logic [1:0] code);
    return ((prev_code == LIGHT_RED)    && (code == LIGHT_GREEN))  ||
           ((prev_code == LIGHT_GREEN)  && (code == LIGHT_YELLOW)) ||
           ((prev_code == LIGHT_YELLOW) && (code == LIGHT_RED));
  endfunction

  // Lowest-numbered active cause wins
  function automatic logic [2:0] encode_fault(input fault_flags_t flags);
    logic [2:0] fc;
    if (flags.conflict) begin
      fc = FC_CONFLICT;
    end else if (flags.invalid) begin
      fc = FC_INVALID;
    end else if (flags.illegal) begin
      fc = FC_ILLEGAL;
    end else if (flags.short_yellow) begin
      fc = FC_SHORT_YELLOW;
    end else if (flags.stuck) begin
      fc = FC_STUCK;
    end else begin
      fc = FC_NONE;
    end
    return fc;
  endfunction

endpackage

// File: rtl/lamp_dwell_tracker.sv
// lamp_dwell_tracker
// Per-direction history: remembers the previous light code and how many
// cycles it has been held, and flags sequence violations for the current code.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   code [1:0]         light code for this direction, this cycle
//   illegal_trans      code changed along a non-permitted edge
//   short_yellow       YELLOW->RED after fewer than MIN_YELLOW yellow cycles
//   stuck              GREEN/YELLOW dwell (including this cycle) > MAX_PHASE
module lamp_dwell_tracker
  import traffic_lamp_monitor_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_PHASE  = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code,
  output logic       illegal_trans,
  output logic       short_yellow,
  output logic       stuck
);

  localparam logic [4:0] MIN_Y_CYC = 5'(MIN_YELLOW);
  // Six bits so MAX_PHASE=31 gives 32, which a saturating 5-bit dwell never reaches
  localparam logic [5:0] STUCK_AT  = 6'(MAX_PHASE + 1);

  logic [1:0] prev_code_q, prev_code_d;
  logic [4:0] dwell_q, dwell_d;
  logic       changed;

  // History update and violation detection for the current cycle
  always_comb begin
    changed     = (code != prev_code_q);
    prev_code_d = code;
    if (changed) begin
      dwell_d = 5'd1;
    end else if (dwell_q == 5'd31) begin
      dwell_d = 5'd31;
    end else begin
      dwell_d = dwell_q + 5'd1;
    end
    illegal_trans = changed && !legal_step(prev_code_q, code);
    // dwell_q still holds the full yellow count on the first red cycle
    short_yellow  = (prev_code_q == LIGHT_YELLOW) && (code == LIGHT_RED) &&
                    (dwell_q < MIN_Y_CYC);
    // Measured on the dwell this cycle completes, so the fault flags in the
    // cycle the limit is exceeded rather than one later
    stuck         = ((code == LIGHT_GREEN) || (code == LIGHT_YELLOW)) &&
                    ({1'b0, dwell_d} >= STUCK_AT);
  end

  // History registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_code_q <= LIGHT_RED;
      dwell_q     <= 5'd0;
    end else begin
      prev_code_q <= prev_code_d;
      dwell_q     <= dwell_d;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Safety monitor between a traffic-light controller and the lamp drivers.
// It re-drives the lamps from the controller codes while the sequence is sane
// and latches into a flashing-red FAULT mode on the first violation.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   main_light [1:0]    main-road code  (RED=00 GREEN=01 YELLOW=10, 11 invalid)
//   side_light [1:0]    side-road code, same encoding
//   fault_clr           operator request to leave FAULT (level)
//   main_lamp  [2:0]    registered one-hot {red,yellow,green}
//   side_lamp  [2:0]    registered one-hot {red,yellow,green}
//   fault               high while in FAULT
//   fault_code [2:0]    latched cause (0 none .. 5 stuck)
//   mode       [1:0]    STARTUP=00 NORMAL=01 FAULT=10
module traffic_lamp_monitor
  import traffic_lamp_monitor_pkg::*;
#(
  parameter int unsigned MIN_YELLOW  = 3,
  parameter int unsigned MAX_PHASE   = 12,
  parameter int unsigned FLASH_HALF  = 4,
  parameter int unsigned STARTUP_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] main_light,
  input  logic [1:0] side_light,
  input  logic       fault_clr,
  output logic [2:0] main_lamp,
  output logic [2:0] side_lamp,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] mode
);

  localparam logic [3:0] STARTUP_LAST = 4'(STARTUP_CYC - 1);
  localparam logic [3:0] FLASH_LAST   = 4'(FLASH_HALF - 1);

  mode_e        state_q, state_d;
  logic [3:0]   startup_cnt_q, startup_cnt_d;
  logic [3:0]   flash_cnt_q, flash_cnt_d;
  logic         flash_q, flash_d;
  logic [2:0]   main_lamp_q, main_lamp_d;
  logic [2:0]   side_lamp_q, side_lamp_d;
  logic         fault_q, fault_d;
  logic [2:0]   fault_code_q, fault_code_d;

  logic         main_illegal, main_short, main_stuck;
  logic         side_illegal, side_short, side_stuck;
  fault_flags_t flags;
  logic         any_fault;
  logic         clear_ok;

  // History runs in every mode so NORMAL starts from valid dwell counts
  lamp_dwell_tracker #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_PHASE  (MAX_PHASE)
  ) u_main_tracker (
    .clk           (clk),
    .reset         (reset),
    .code          (main_light),
    .illegal_trans (main_illegal),
    .short_yellow  (main_short),
    .stuck         (main_stuck)
  );

  lamp_dwell_tracker #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_PHASE  (MAX_PHASE)
  ) u_side_tracker (
    .clk           (clk),
    .reset         (reset),
    .code          (side_light),
    .illegal_trans (side_illegal),
    .short_yellow  (side_short),
    .stuck         (side_stuck)
  );

  // Combine both directions into one prioritised set of fault conditions
  always_comb begin
    flags.conflict     = (main_light != LIGHT_RED) && (side_light != LIGHT_RED);
    flags.invalid      = (main_light == LIGHT_INVALID) || (side_light == LIGHT_INVALID);
    flags.illegal      = main_illegal || side_illegal;
    flags.short_yellow = main_short || side_short;
    flags.stuck        = main_stuck || side_stuck;
    any_fault          = |flags;
    clear_ok           = fault_clr && (main_light == LIGHT_RED) &&
                         (side_light == LIGHT_RED);
  end

  // Mode state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MODE_STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      MODE_STARTUP: begin
        if (startup_cnt_q == STARTUP_LAST) begin
          state_d = MODE_NORMAL;
        end else begin
          state_d = MODE_STARTUP;
        end
      end
      MODE_NORMAL: begin
        if (any_fault) begin
          state_d = MODE_FAULT;
        end else begin
          state_d = MODE_NORMAL;
        end
      end
      MODE_FAULT: begin
        if (clear_ok) begin
          state_d = MODE_STARTUP;
        end else begin
          state_d = MODE_FAULT;
        end
      end
      default: state_d = MODE_FAULT;
    endcase
  end

  // Counters, fault latch and lamp drive for the coming cycle
  always_comb begin
    // Startup hold counter restarts whenever STARTUP is (re)entered
    if ((state_q == MODE_STARTUP) && (state_d == MODE_STARTUP)) begin
      startup_cnt_d = startup_cnt_q + 4'd1;
    end else begin
      startup_cnt_d = 4'd0;
    end

    case (state_q)
      MODE_STARTUP: fault_code_d = FC_NONE;
      MODE_NORMAL: begin
        if (any_fault) begin
          fault_code_d = encode_fault(flags);
        end else begin
          fault_code_d = FC_NONE;
        end
      end
      MODE_FAULT: begin
        if (state_d == MODE_STARTUP) begin
          fault_code_d = FC_NONE;
        end else begin
          fault_code_d = fault_code_q;
        end
      end
      default: fault_code_d = FC_INVALID;
    endcase

    // Flash starts lit on the first FAULT cycle, then toggles every FLASH_HALF
    if (state_d == MODE_FAULT) begin
      if (state_q != MODE_FAULT) begin
        flash_d     = 1'b1;
        flash_cnt_d = 4'd0;
      end else if (flash_cnt_q == FLASH_LAST) begin
        flash_d     = ~flash_q;
        flash_cnt_d = 4'd0;
      end else begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q + 4'd1;
      end
    end else begin
      flash_d     = 1'b0;
      flash_cnt_d = 4'd0;
    end

    fault_d = (state_d == MODE_FAULT);

    // Lamps follow the codes only while NORMAL; all-red otherwise
    if (state_d == MODE_FAULT) begin
      main_lamp_d = {flash_d, 2'b00};
      side_lamp_d = {flash_d, 2'b00};
    end else if (state_q == MODE_NORMAL) begin
      main_lamp_d = decode_lamp(main_light);
      side_lamp_d = decode_lamp(side_light);
    end else begin
      main_lamp_d = LAMP_RED;
      side_lamp_d = LAMP_RED;
    end
  end

  // Output and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startup_cnt_q <= 4'd0;
      flash_cnt_q   <= 4'd0;
      flash_q       <= 1'b0;
      main_lamp_q   <= LAMP_RED;
      side_lamp_q   <= LAMP_RED;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
    end else begin
      startup_cnt_q <= startup_cnt_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_q       <= flash_d;
      main_lamp_q   <= main_lamp_d;
      side_lamp_q   <= side_lamp_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
    end
  end

  assign main_lamp  = main_lamp_q;
  assign side_lamp  = side_lamp_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor
// Table-driven directed bench for traffic_lamp_monitor plus hand-written
// multi-cycle sequences (normal cycling, short yellow, priority, stuck,
// illegal transition, reset during flash).
module tb_traffic_lamp_monitor;
  import traffic_lamp_monitor_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       fault_clr;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] mode;

  int checks;
  int errors;

  typedef struct {
    logic [1:0] m;
    logic [1:0] s;
    logic       clr;
    logic [2:0] exp_ml;
    logic [2:0] exp_sl;
    logic       exp_f;
    logic [2:0] exp_fc;
    logic [1:0] exp_mode;
  } vec_t;

  vec_t vecs[$];

  traffic_lamp_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .main_light (main_light),
    .side_light (side_light),
    .fault_clr  (fault_clr),
    .main_lamp  (main_lamp),
    .side_lamp  (side_lamp),
    .fault      (fault),
    .fault_code (fault_code),
    .mode       (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ml, input logic [2:0] sl,
                           input logic f, input logic [2:0] fc, input logic [1:0] md);
    check({tag, " main_lamp"}, 8'(main_lamp), 8'(ml));
    check({tag, " side_lamp"}, 8'(side_lamp), 8'(sl));
    check({tag, " fault"}, 8'(fault), 8'(f));
    check({tag, " fault_code"}, 8'(fault_code), 8'(fc));
    check({tag, " mode"}, 8'(mode), 8'(md));
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge
  task automatic step(input logic [1:0] m, input logic [1:0] s, input logic c);
    main_light = m;
    side_light = s;
    fault_clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] m, input logic [1:0] s, input logic c,
                     input logic [2:0] ml, input logic [2:0] sl, input logic f,
                     input logic [2:0] fc, input logic [1:0] md);
    vec_t v;
    v.m = m; v.s = s; v.clr = c; v.exp_ml = ml; v.exp_sl = sl;
    v.exp_f = f; v.exp_fc = fc; v.exp_mode = md;
    vecs.push_back(v);
  endtask

  // Reset, release, and run through the 4-cycle all-red startup hold
  task automatic reset_to_normal(input string tag);
    reset = 1'b1;
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    fault_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) step(LIGHT_RED, LIGHT_RED, 1'b0);
    check({tag, " startup->normal mode"}, 8'(mode), 8'h01);
  endtask

  function automatic logic [2:0] exp_lamp(input logic [1:0] code);
    logic [2:0] r;
    case (code)
      2'b00:   r = 3'b100;
      2'b01:   r = 3'b001;
      2'b10:   r = 3'b010;
      default: r = 3'b111;
    endcase
    return r;
  endfunction

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] X = 2'b11;

  initial begin
    logic [1:0] m;
    logic [1:0] s;
    int         p;
    checks = 0;
    errors = 0;

    // ---- vector table ----
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b01);
    add(G, R, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, 2'b01);
    add(G, R, 1'b0, 3'b001, 3'b100, 1'b0, 3'd0, 2'b01);
    add(Y, R, 1'b0, 3'b010, 3'b100, 1'b0, 3'd0, 2'b01);
    add(Y, R, 1'b0, 3'b010, 3'b100, 1'b0, 3'd0, 2'b01);
    add(Y, R, 1'b0, 3'b010, 3'b100, 1'b0, 3'd0, 2'b01);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b01);
    add(R, G, 1'b0, 3'b100, 3'b001, 1'b0, 3'd0, 2'b01);
    add(G, G, 1'b0, 3'b100, 3'b100, 1'b1, 3'd1, 2'b10);   // conflict
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b1, 3'd1, 2'b10);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b1, 3'd1, 2'b10);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b1, 3'd1, 2'b10);
    add(R, R, 1'b0, 3'b000, 3'b000, 1'b1, 3'd1, 2'b10);   // flash off
    add(G, R, 1'b1, 3'b000, 3'b000, 1'b1, 3'd1, 2'b10);   // clear refused
    add(R, R, 1'b0, 3'b000, 3'b000, 1'b1, 3'd1, 2'b10);
    add(R, R, 1'b0, 3'b000, 3'b000, 1'b1, 3'd1, 2'b10);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b1, 3'd1, 2'b10);   // flash on
    add(R, R, 1'b1, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);   // clear accepted
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    add(R, R, 1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 2'b01);
    add(R, R, 1'b1, 3'b100, 3'b100, 1'b0, 3'd0, 2'b01);   // clr ignored
    add(G, R, 1'b1, 3'b001, 3'b100, 1'b0, 3'd0, 2'b01);

    // ---- reset state ----
    reset = 1'b1;
    main_light = R;
    side_light = R;
    fault_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].m, vecs[i].s, vecs[i].clr);
      check_all($sformatf("v%0d", i), vecs[i].exp_ml, vecs[i].exp_sl,
                vecs[i].exp_f, vecs[i].exp_fc, vecs[i].exp_mode);
    end

    // ---- 200 cycles of legal alternating phases ----
    reset_to_normal("run");
    for (int t = 0; t < 200; t++) begin
      p = t % 18;
      m = (p < 6) ? G : (p < 9) ? Y : R;
      s = (p < 9) ? R : (p < 15) ? G : Y;
      step(m, s, 1'b0);
      check($sformatf("run%0d main_lamp", t), 8'(main_lamp), 8'(exp_lamp(m)));
      check($sformatf("run%0d side_lamp", t), 8'(side_lamp), 8'(exp_lamp(s)));
      check($sformatf("run%0d fault", t), 8'(fault), 8'h00);
    end

    // ---- short yellow ----
    reset_to_normal("shorty");
    step(G, R, 1'b0);
    step(Y, R, 1'b0);
    step(Y, R, 1'b0);
    check("shorty pre fault", 8'(fault), 8'h00);
    step(R, R, 1'b0);
    check_all("shorty", 3'b100, 3'b100, 1'b1, 3'd4, 2'b10);

    // ---- priority: invalid beats short yellow/illegal ----
    reset_to_normal("prio");
    step(G, R, 1'b0);
    step(Y, R, 1'b0);
    step(Y, R, 1'b0);
    step(R, X, 1'b0);
    check_all("prio", 3'b100, 3'b100, 1'b1, 3'd2, 2'b10);

    // ---- stuck green ----
    reset_to_normal("stuck");
    repeat (12) step(G, R, 1'b0);
    check("stuck dwell12 fault", 8'(fault), 8'h00);
    check("stuck dwell12 lamp", 8'(main_lamp), 8'h01);
    step(G, R, 1'b0);
    check_all("stuck", 3'b100, 3'b100, 1'b1, 3'd5, 2'b10);

    // ---- illegal GREEN->RED, then reset during flash ----
    reset_to_normal("illegal");
    step(G, R, 1'b0);
    step(G, R, 1'b0);
    step(R, R, 1'b0);
    check_all("illegal", 3'b100, 3'b100, 1'b1, 3'd3, 2'b10);
    repeat (4) step(R, R, 1'b0);
    check_all("flash off", 3'b000, 3'b000, 1'b1, 3'd3, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    check_all("async reset", 3'b100, 3'b100, 1'b0, 3'd0, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step(R, R, 1'b0);
    check("restart hold mode", 8'(mode), 8'h00);
    step(R, R, 1'b0);
    check("restart normal mode", 8'(mode), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
